// File: rtl/chip_select_controller_pkg.sv
// Shared types and default region map for the 68000 chip-select controller.
// Region r sits in the r-th slice of every packed map (region 0 in the LSBs).
package chip_select_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_BERR = 2'd3
  } cs_state_e;

  localparam logic [1:0] A15_ANY = 2'b00;
  localparam logic [1:0] A15_LO  = 2'b10;
  localparam logic [1:0] A15_HI  = 2'b11;

  localparam int CSC_NUM_REGIONS = 6;
  localparam int CSC_WS_W        = 4;

  localparam logic [15:0] SEG_FLASH  = 16'h0001 | 16'h4000;
  localparam logic [15:0] SEG_WRAM   = 16'h0002;
  localparam logic [15:0] SEG_EEPROM = 16'h0004;
  localparam logic [15:0] SEG_EXPAN  = 16'h0008;
  localparam logic [15:0] SEG_PIO    = 16'h8000;
  localparam logic [15:0] SEG_SPARE  = 16'h0000;

  localparam logic [CSC_NUM_REGIONS*16-1:0] CSC_REGION_SEG = {
    SEG_SPARE, SEG_PIO, SEG_EXPAN,
    SEG_EEPROM, SEG_WRAM, SEG_FLASH
  };

  localparam logic [CSC_NUM_REGIONS*2-1:0] CSC_REGION_A15 = {
    A15_LO, A15_HI, A15_ANY,
    A15_ANY, A15_ANY, A15_ANY
  };

  localparam logic [CSC_NUM_REGIONS*CSC_WS_W-1:0] CSC_REGION_WS = {
    4'd0, 4'd3, 4'd0,
    4'd1, 4'd0, 4'd2
  };

  localparam logic [CSC_NUM_REGIONS-1:0] CSC_REGION_EXT = 6'b001000;

  function automatic logic a15_ok(
    input logic [1:0] qual,
    input logic       a15
  );
    return !qual[1] || (a15 == qual[0]);
  endfunction

endpackage

// File: rtl/chip_select_controller_if.sv
// CPU-side bus bundle of the chip-select controller.
// The controller is the slave; the CPU/bench side is the master.
interface chip_select_controller_if
  import chip_select_controller_pkg::*;
#(
  parameter int NUM_REGIONS = CSC_NUM_REGIONS
);

  logic                   as_n;
  logic [3:0]             adh;
  logic                   adm15;
  logic                   ext_dtack_n;
  logic [NUM_REGIONS-1:0] cs_n;
  logic                   dtack_n;
  logic                   berr_n;

  modport master (
    output as_n,
    output adh,
    output adm15,
    output ext_dtack_n,
    input  cs_n,
    input  dtack_n,
    input  berr_n
  );

  modport slave (
    input  as_n,
    input  adh,
    input  adm15,
    input  ext_dtack_n,
    output cs_n,
    output dtack_n,
    output berr_n
  );

endinterface

// File: rtl/chip_select_controller_region_match.sv
// Combinational priority match of a segment/A15 pair to a region index.
// Lowest matching index wins; force0 selects region 0 unconditionally.
module cs_region_match
  import chip_select_controller_pkg::*;
#(
  parameter int NUM_REGIONS = CSC_NUM_REGIONS,
  parameter int IDX_W       = 3,
  parameter logic [NUM_REGIONS*16-1:0] REGION_SEG = CSC_REGION_SEG,
  parameter logic [NUM_REGIONS*2-1:0]  REGION_A15 = CSC_REGION_A15
) (
  input  logic [3:0]       seg,
  input  logic             a15,
  input  logic             force0,
  output logic [IDX_W-1:0] idx,
  output logic             hit
);

  always_comb begin
    logic [15:0] map;
    logic [1:0]  qual;
    idx  = '0;
    hit  = force0;
    map  = '0;
    qual = '0;
    if (!force0) begin
      for (int r = NUM_REGIONS - 1; r >= 0; r--) begin
        map  = REGION_SEG[r*16 +: 16];
        qual = REGION_A15[r*2 +: 2];
        if (map[seg] && a15_ok(qual, a15)) begin
          hit = 1'b1;
          idx = IDX_W'(r);
        end
      end
    end
  end

endmodule

// File: rtl/chip_select_controller.sv
// Registered 68000 chip-select decoder with wait states, DTACK and BERR.
// Owns the boot overlay flag that maps flash over work RAM after reset.
module chip_select_controller
  import chip_select_controller_pkg::*;
#(
  parameter int NUM_REGIONS = CSC_NUM_REGIONS,
  parameter int WS_W        = CSC_WS_W,
  parameter logic [NUM_REGIONS*16-1:0]   REGION_SEG = CSC_REGION_SEG,
  parameter logic [NUM_REGIONS*2-1:0]    REGION_A15 = CSC_REGION_A15,
  parameter logic [NUM_REGIONS*WS_W-1:0] REGION_WS  = CSC_REGION_WS,
  parameter logic [NUM_REGIONS-1:0]      REGION_EXT = CSC_REGION_EXT,
  parameter int         TIMEOUT     = 64,
  parameter logic [3:0] OVERLAY_SEG = 4'h1,
  parameter logic [3:0] MIRROR_SEG  = 4'hE
) (
  input  logic clk,
  input  logic reset_n,
  chip_select_controller_if.slave bus,
  input  logic overlay_clr,
  output logic overlay
);

  localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam int TW    = $clog2(TIMEOUT + 1);

  cs_state_e state_q, state_d;

  logic as_meta_q, as_meta_d;
  logic as_s_q, as_s_d;
  logic ext_meta_q, ext_meta_d;
  logic ext_s_q, ext_s_d;
  logic [1:0] prime_q, prime_d;
  logic armed_q, armed_d;
  logic hit_q, hit_d;
  logic ext_q, ext_d;
  logic [WS_W-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [NUM_REGIONS-1:0] cs_n_q, cs_n_d;
  logic dtack_n_q, dtack_n_d;
  logic berr_n_q, berr_n_d;
  logic overlay_q, overlay_d;

  logic [IDX_W-1:0] m_idx;
  logic             m_hit;
  logic             force0;

  logic [WS_W-1:0] ws_tab  [NUM_REGIONS];
  logic            ext_tab [NUM_REGIONS];

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_tab
    assign ws_tab[g]  = REGION_WS[g*WS_W +: WS_W];
    assign ext_tab[g] = REGION_EXT[g];
  end

  assign force0 = overlay_q && (bus.adh == OVERLAY_SEG);

  cs_region_match #(
    .NUM_REGIONS (NUM_REGIONS),
    .IDX_W       (IDX_W),
    .REGION_SEG  (REGION_SEG),
    .REGION_A15  (REGION_A15)
  ) u_match (
    .seg    (bus.adh),
    .a15    (bus.adm15),
    .force0 (force0),
    .idx    (m_idx),
    .hit    (m_hit)
  );

  always_comb begin
    as_meta_d  = bus.as_n;
    as_s_d     = as_meta_q;
    ext_meta_d = bus.ext_dtack_n;
    ext_s_d    = ext_meta_q;
    // prime_q[1] marks the sync chain as holding real strobe samples
    prime_d    = {prime_q[0], 1'b1};
    state_d    = state_q;
    armed_d    = armed_q;
    hit_d      = hit_q;
    ext_d      = ext_q;
    cnt_d      = cnt_q;
    tcnt_d     = tcnt_q;
    cs_n_d     = cs_n_q;
    dtack_n_d  = dtack_n_q;
    berr_n_d   = berr_n_q;
    overlay_d  = overlay_q & ~overlay_clr;

    unique case (state_q)
      ST_IDLE: begin
        cs_n_d    = '1;
        dtack_n_d = 1'b1;
        berr_n_d  = 1'b1;
        if (armed_q && !as_s_q) begin
          armed_d = 1'b0;
          hit_d   = m_hit;
          ext_d   = m_hit && ext_tab[m_idx];
          cnt_d   = ws_tab[m_idx];
          // tcnt counts cycles since decode, decode cycle included
          tcnt_d  = TW'(1);
          if (m_hit) begin
            cs_n_d = ~(NUM_REGIONS'(1) << m_idx);
            if (bus.adh == MIRROR_SEG) overlay_d = 1'b0;
          end
          if (m_hit && !ext_tab[m_idx] && ws_tab[m_idx] == '0) begin
            state_d   = ST_ACK;
            dtack_n_d = 1'b0;
          end else begin
            state_d = ST_WAIT;
          end
        end else if (as_s_q && prime_q[1]) begin
          armed_d = 1'b1;
        end
      end

      ST_WAIT: begin
        if (as_s_q) begin
          state_d = ST_IDLE;
          cs_n_d  = '1;
        end else if (hit_q && !ext_q) begin
          if (cnt_q <= WS_W'(1)) begin
            state_d   = ST_ACK;
            dtack_n_d = 1'b0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end else if (ext_q && !ext_s_q) begin
          state_d   = ST_ACK;
          dtack_n_d = 1'b0;
        end else if (tcnt_q >= TW'(TIMEOUT - 1)) begin
          state_d  = ST_BERR;
          berr_n_d = 1'b0;
          cs_n_d   = '1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end

      ST_ACK, ST_BERR: begin
        if (as_s_q) begin
          state_d   = ST_IDLE;
          cs_n_d    = '1;
          dtack_n_d = 1'b1;
          berr_n_d  = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      as_meta_q  <= 1'b1;
      as_s_q     <= 1'b1;
      ext_meta_q <= 1'b1;
      ext_s_q    <= 1'b1;
      prime_q    <= '0;
      armed_q    <= 1'b0;
      hit_q      <= 1'b0;
      ext_q      <= 1'b0;
      cnt_q      <= '0;
      tcnt_q     <= '0;
      cs_n_q     <= '1;
      dtack_n_q  <= 1'b1;
      berr_n_q   <= 1'b1;
      overlay_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      as_meta_q  <= as_meta_d;
      as_s_q     <= as_s_d;
      ext_meta_q <= ext_meta_d;
      ext_s_q    <= ext_s_d;
      prime_q    <= prime_d;
      armed_q    <= armed_d;
      hit_q      <= hit_d;
      ext_q      <= ext_d;
      cnt_q      <= cnt_d;
      tcnt_q     <= tcnt_d;
      cs_n_q     <= cs_n_d;
      dtack_n_q  <= dtack_n_d;
      berr_n_q   <= berr_n_d;
      overlay_q  <= overlay_d;
    end
  end

  assign bus.cs_n    = cs_n_q;
  assign bus.dtack_n = dtack_n_q;
  assign bus.berr_n  = berr_n_q;
  assign overlay     = overlay_q;

endmodule

// File: tb/tb_chip_select_controller.sv
// Directed bench for chip_select_controller: vector table plus
// hand-written sequences for overlay, EXT, abort, timeout and reset.
module tb_chip_select_controller;

  logic clk = 1'b0;
  logic reset_n;
  logic overlay_clr;
  logic overlay;
  int   n_cmp = 0;
  int   n_err = 0;

  chip_select_controller_if #(.NUM_REGIONS(6)) bus();

  chip_select_controller dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .overlay_clr (overlay_clr),
    .overlay     (overlay)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] adh;
    logic       a15;
    logic [5:0] cs;
    logic [7:0] lat;
    logic       be;
  } vec_t;

  vec_t vt [8];

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // returns just after the decode edge D
  task automatic begin_cycle(input logic [3:0] a, input logic m);
    @(negedge clk);
    bus.adh   = a;
    bus.adm15 = m;
    bus.as_n  = 1'b0;
    step(3);
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    while (bus.dtack_n && bus.berr_n && lat < 200) begin
      step(1);
      lat++;
    end
  endtask

  task automatic end_cycle(input string nm,
                           input logic dt,
                           input logic be);
    @(negedge clk);
    bus.as_n = 1'b1;
    step(2);
    check({nm, "_hold"}, {30'd0, bus.dtack_n, bus.berr_n},
          {30'd0, dt, be});
    step(1);
    check({nm, "_rel"}, {24'd0, bus.dtack_n, bus.berr_n, bus.cs_n},
          {24'd0, 2'b11, 6'h3f});
    step(2);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end

  initial begin
    int lat;
    vt[0] = '{4'h1, 1'b0, 6'b111101, 8'd0,  1'b0};
    vt[1] = '{4'h1, 1'b1, 6'b111101, 8'd0,  1'b0};
    vt[2] = '{4'h0, 1'b0, 6'b111110, 8'd2,  1'b0};
    vt[3] = '{4'hE, 1'b1, 6'b111110, 8'd2,  1'b0};
    vt[4] = '{4'h2, 1'b0, 6'b111011, 8'd1,  1'b0};
    vt[5] = '{4'hF, 1'b1, 6'b101111, 8'd3,  1'b0};
    vt[6] = '{4'hF, 1'b0, 6'b111111, 8'd63, 1'b1};
    vt[7] = '{4'h5, 1'b0, 6'b111111, 8'd63, 1'b1};

    reset_n         = 1'b0;
    overlay_clr     = 1'b0;
    bus.as_n        = 1'b1;
    bus.adh         = 4'h0;
    bus.adm15       = 1'b0;
    bus.ext_dtack_n = 1'b1;
    step(3);
    check("reset_out", {24'd0, bus.dtack_n, bus.berr_n, bus.cs_n},
          {24'd0, 2'b11, 6'h3f});
    check("reset_ovl", overlay, 1);
    @(negedge clk);
    reset_n = 1'b1;
    step(5);

    // boot overlay redirects segment 1 to flash
    begin_cycle(4'h1, 1'b0);
    check("ovl_cs", bus.cs_n, 6'b111110);
    wait_resp(lat);
    check("ovl_lat", lat, 2);
    check("ovl_still", overlay, 1);
    end_cycle("ovl", 1'b0, 1'b1);

    // first mirror access clears overlay at decode
    @(negedge clk);
    bus.adh   = 4'hE;
    bus.adm15 = 1'b0;
    bus.as_n  = 1'b0;
    step(2);
    check("mir_pre_ovl", overlay, 1);
    step(1);
    check("mir_cs", bus.cs_n, 6'b111110);
    check("mir_post_ovl", overlay, 0);
    wait_resp(lat);
    check("mir_lat", lat, 2);
    end_cycle("mir", 1'b0, 1'b1);

    begin_cycle(4'h1, 1'b0);
    check("wram_cs", bus.cs_n, 6'b111101);
    wait_resp(lat);
    check("wram_lat", lat, 0);
    // short high glitch between edges must not end the cycle
    @(negedge clk);
    bus.as_n = 1'b1;
    #2;
    bus.as_n = 1'b0;
    step(4);
    check("b2b_dtack", bus.dtack_n, 0);
    end_cycle("wram", 1'b0, 1'b1);

    for (int i = 0; i < 8; i++) begin
      begin_cycle(vt[i].adh, vt[i].a15);
      check($sformatf("v%0d_cs", i), bus.cs_n, vt[i].cs);
      wait_resp(lat);
      check($sformatf("v%0d_lat", i), lat, vt[i].lat);
      check($sformatf("v%0d_kind", i), {bus.dtack_n, bus.berr_n},
            vt[i].be ? 2'b10 : 2'b01);
      step(10);
      check($sformatf("v%0d_held", i),
            {bus.dtack_n, bus.berr_n, bus.cs_n},
            vt[i].be ? {2'b10, 6'h3f} : {2'b01, vt[i].cs});
      end_cycle($sformatf("v%0d", i), vt[i].be, !vt[i].be);
    end

    // EXT region answered by ext_dtack_n
    begin_cycle(4'h3, 1'b0);
    check("ext_cs", bus.cs_n, 6'b110111);
    step(10);
    check("ext_wait", {bus.dtack_n, bus.berr_n}, 2'b11);
    @(negedge clk);
    bus.ext_dtack_n = 1'b0;
    wait_resp(lat);
    check("ext_lat", lat, 3);
    check("ext_dtack", bus.dtack_n, 0);
    end_cycle("ext", 1'b0, 1'b1);
    bus.ext_dtack_n = 1'b1;

    // EXT region never answered
    begin_cycle(4'h3, 1'b0);
    wait_resp(lat);
    check("extto_lat", lat, 63);
    check("extto_out", {bus.dtack_n, bus.berr_n, bus.cs_n},
          {2'b10, 6'h3f});
    end_cycle("extto", 1'b1, 1'b0);

    // ext answer coincident with expiry: ACK wins
    begin_cycle(4'h3, 1'b0);
    step(60);
    @(negedge clk);
    bus.ext_dtack_n = 1'b0;
    step(3);
    check("tie_ack", {bus.dtack_n, bus.berr_n}, 2'b01);
    end_cycle("tie_ack", 1'b0, 1'b1);
    bus.ext_dtack_n = 1'b1;

    // strobe release coincident with expiry: abort wins
    begin_cycle(4'h5, 1'b0);
    step(60);
    @(negedge clk);
    bus.as_n = 1'b1;
    step(3);
    check("tie_abort", {bus.dtack_n, bus.berr_n}, 2'b11);
    step(2);
    check("tie_abort2", bus.berr_n, 1);

    // abort during wait states, coincident with the last wait state
    begin_cycle(4'hF, 1'b1);
    check("abt_cs", bus.cs_n, 6'b101111);
    @(negedge clk);
    bus.as_n = 1'b1;
    step(2);
    check("abt_mid", {bus.dtack_n, bus.cs_n}, {1'b1, 6'b101111});
    step(1);
    check("abt_out", {bus.dtack_n, bus.berr_n, bus.cs_n},
          {2'b11, 6'h3f});
    step(3);
    check("abt_quiet", bus.dtack_n, 1);

    // reset in WAIT with the strobe still low
    begin_cycle(4'hF, 1'b1);
    step(1);
    check("rst_pre", bus.cs_n, 6'b101111);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rst_async", {bus.dtack_n, bus.berr_n, bus.cs_n},
          {2'b11, 6'h3f});
    check("rst_ovl", overlay, 1);
    @(negedge clk);
    reset_n = 1'b1;
    step(10);
    check("rst_nodec", {bus.dtack_n, bus.berr_n, bus.cs_n},
          {2'b11, 6'h3f});
    @(negedge clk);
    bus.as_n = 1'b1;
    step(5);
    begin_cycle(4'h1, 1'b0);
    check("rst_dec_cs", bus.cs_n, 6'b111110);
    wait_resp(lat);
    check("rst_dec_lat", lat, 2);
    end_cycle("rst_dec", 1'b0, 1'b1);

    // software overlay clear
    check("clr_pre", overlay, 1);
    @(negedge clk);
    overlay_clr = 1'b1;
    @(negedge clk);
    overlay_clr = 1'b0;
    #1;
    check("clr_post", overlay, 0);
    begin_cycle(4'h1, 1'b0);
    check("clr_cs", bus.cs_n, 6'b111101);
    wait_resp(lat);
    check("clr_lat", lat, 0);
    end_cycle("clr", 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/chip_select_controller.md
Name: chip_select_controller

Overview:
- Parametrised, registered successor to the combinational megabyte-segment decoder.
- Decodes a 68000-style bus cycle into NUM_REGIONS active-low chip selects.
- Generates per-region wait states, DTACK, and bus-error timeouts.
- Holds the boot overlay flag that maps flash over work RAM until the first jump into the flash mirror.
- Sits between the CPU bus and all memory/peripheral chip enables; sole owner of dtack_n/berr_n.

Parameters:
- NUM_REGIONS, 6: number of chip-select outputs; index 0 is flash (overlay target).
- WS_W, 4: width of per-region wait-state count.
- REGION_SEG, {16'h0001|16'h4000, 16'h0002, 16'h0004, 16'h0008, 16'h8000, 16'h0000}: packed NUM_REGIONS*16; bit s set means region matches adh==s.
- REGION_A15, packed NUM_REGIONS*2: 2'b00 any, 2'b10 requires adm[15]=0, 2'b11 requires adm[15]=1.
- REGION_WS, packed NUM_REGIONS*WS_W: wait states before DTACK.
- REGION_EXT, packed NUM_REGIONS*1: 1 means DTACK comes from ext_dtack_n, not the counter.
- TIMEOUT, 64: cycles before berr_n for unmatched or unanswered EXT cycles; counter width $clog2(TIMEOUT+1).
- OVERLAY_SEG, 4'h1: segment redirected to region 0 while overlay is set.
- MIRROR_SEG, 4'hE: segment whose first access clears overlay.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- as_n  in  1  CPU address strobe (asynchronous to clk)
- adh  in  4  address bits 23:20
- adm15  in  1  address bit 15
- ext_dtack_n  in  1  DTACK from EXT regions (asynchronous)
- overlay_clr  in  1  software clear of overlay, one clk pulse
- cs_n  out  NUM_REGIONS  registered active-low chip selects
- dtack_n  out  1  registered, active low
- berr_n  out  1  registered, active low
- overlay  out  1  overlay flag

Behaviour:
- Synchronisers: as_n and ext_dtack_n each pass through 2 flops, giving as_s and ext_s. Both reset to 1.
- Reset values: cs_n all 1, dtack_n=1, berr_n=1, overlay=1, state IDLE, counters 0.
- States: IDLE, WAIT, ACK, BERR.
- Decode cycle D is the first clk edge in IDLE where as_s==0.
  - eff_seg = (overlay && adh==OVERLAY_SEG) ? force region 0 : adh.
  - Match uses REGION_SEG and REGION_A15. When several regions match, the lowest index wins.
  - The winning region index is latched at D; address is not re-sampled later in the cycle.
- On a match at D:
  - cs_n[r] goes low at D+1.
  - Non-EXT region: load count = REGION_WS[r].
    - WS=0: go straight to ACK, so dtack_n goes low at D+1.
    - Otherwise go to WAIT; dtack_n goes low at D+1+WS.
  - EXT region: go to WAIT; on ext_s==0, go to ACK at the next edge.
- On no match at D: no cs_n asserted, go to WAIT with the timeout counter only.
- Timeout: counter runs in WAIT for unmatched and EXT cycles. At TIMEOUT cycles go to BERR; berr_n goes low and cs_n goes high.
- ACK/BERR hold until as_s==1. At the following edge, all outputs go high and state returns to IDLE.
- Abort: as_s==1 in WAIT returns to IDLE next edge with no DTACK/BERR and cs_n released.
- as_s must be seen high in IDLE before a new decode. Back-to-back strobes without a high sample are a single cycle.
- Overlay clear:
  - Set at reset.
  - Cleared at D when adh==MIRROR_SEG and a region matches, or when overlay_clr==1 in any state.
  - Clearing at D does not alter the decode of the same cycle.
  - Once cleared, overlay stays 0 until reset.
- Simultaneous events: timeout expiry coincident with ext_s==0 gives ACK priority. as_s==1 coincident with expiry gives abort priority.
- Reset mid-cycle: all outputs go high immediately (async); the next decode requires as_s to go high and then low again.

Decomposition:
- Shared package holds the state encoding localparams (IDLE/WAIT/ACK/BERR), the A15 qualifier codes, and the default region map constants (flash/wram/eeprom/expansion/pio/spare).
- One sub-module, cs_region_match: a purely combinational priority match of eff_seg/adm15 to a region index plus a valid bit.
- Synchronisers and the FSM stay in the top level.

Test Plan:
1. Reset, then as_n low with adh=1, adm15=0, overlay=1 -> cs_n[0] low at D+1 (flash overlay), cs_n[1] stays high; dtack_n after REGION_WS[0] cycles.
2. Access adh=E, then adh=1 -> overlay=1 during the first cycle; overlay=0 afterwards; second cycle asserts cs_n[1] only.
3. adh=F, adm15=1, REGION_WS=3 -> cs_n[4] low at D+1, dtack_n low exactly at D+4; both high one edge after as_s rises.
4. adh=5 (unmatched) held for 80 cycles -> no cs_n, berr_n low at D+64, released after as_n high; dtack_n never low.
5. EXT region with ext_dtack_n low 10 cycles after D -> dtack_n low 3 cycles later (sync+1); with ext held high, berr_n at D+64.
6. reset_n pulsed low while in WAIT -> cs_n/dtack_n high asynchronously, overlay=1; as_n still low after reset produces no decode until as_n toggles high then low.
